// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch inputs, IMEM address/data and the IF/ID
// register with its decoded fields. master = fetch stage, slave = the rest
// of the pipeline (hazard unit, EX, IMEM, decode).
interface fetch_stage_if #(
    parameter int WL  = 32,
    parameter int HWL = 16
);
    logic           Stall;
    logic           BranchTaken;
    logic [WL-1:0]  BranchTarget;
    logic [WL-1:0]  PCF;
    logic [WL-1:0]  InstrF;
    logic [WL-1:0]  InstrD;
    logic [WL-1:0]  PCp4D;
    logic           ValidD;
    logic [5:0]     OpD;
    logic [4:0]     RsD;
    logic [4:0]     RtD;
    logic [4:0]     RdD;
    logic [4:0]     ShamtD;
    logic [5:0]     FunctD;
    logic [HWL-1:0] ImmD;
    logic           JumpD;
    logic [31:0]    FetchCount;

    modport master (
        input  Stall, BranchTaken, BranchTarget, InstrF,
        output PCF, InstrD, PCp4D, ValidD, OpD, RsD, RtD, RdD, ShamtD,
               FunctD, ImmD, JumpD, FetchCount
    );

    modport slave (
        output Stall, BranchTaken, BranchTarget, InstrF,
        input  PCF, InstrD, PCp4D, ValidD, OpD, RsD, RtD, RdD, ShamtD,
               FunctD, ImmD, JumpD, FetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register. Owns the PC, presents it to IMEM,
// captures the returned word into IF/ID and slices it into decode fields.
// Redirect priority in RUN: EX branch > stall > ID jump > sequential fetch.
module fetch_stage #(
    parameter int            WL       = 32,
    parameter int            HWL      = 16,
    parameter logic [WL-1:0] RESET_PC = '0,
    parameter logic [WL-1:0] NOP      = '0
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
);
    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [WL-1:0] r_pc;
    logic [WL-1:0] r_instr;
    logic [WL-1:0] r_pcp4;
    logic          r_valid;
    logic [31:0]   r_count;

    logic [WL-1:0] w_pc_nxt;
    logic [WL-1:0] w_instr_nxt;
    logic [WL-1:0] w_pcp4_nxt;
    logic          w_valid_nxt;
    logic [31:0]   w_count_nxt;

    logic [WL-1:0] w_pc_plus4;
    logic [WL-1:0] w_jump_target;
    logic          w_jump;

    // Sequential PC wraps modulo 2^WL; low two bits pass through untouched.
    assign w_pc_plus4    = r_pc + WL'(4);
    // J/JAL resolved in ID: only a real (non-bubble) instruction may jump.
    assign w_jump        = r_valid & ((r_instr[31:26] == 6'h02) ||
                                      (r_instr[31:26] == 6'h03));
    assign w_jump_target = {r_pcp4[WL-1:WL-4], r_instr[25:0], 2'b00};

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_BOOT;
        else     r_state <= w_state_nxt;
    end

    // FSM next state: BOOT lasts exactly one cycle, RUN is steady state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // Next PC and IF/ID contents; first matching redirect rule wins.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pcp4_nxt  = r_pcp4;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        if (r_state == ST_BOOT) begin
            // PC held at RESET_PC, IF/ID stays a bubble; hazards ignored.
            w_instr_nxt = NOP;
            w_pcp4_nxt  = '0;
            w_valid_nxt = 1'b0;
        end else if (bus.BranchTaken) begin
            // Older instruction in EX redirects; whatever sits in ID
            // (stalled or not) is wrong-path, so flush it.
            w_pc_nxt    = bus.BranchTarget;
            w_instr_nxt = NOP;
            w_pcp4_nxt  = '0;
            w_valid_nxt = 1'b0;
        end else if (bus.Stall) begin
            // hold everything
        end else if (w_jump) begin
            // One-bubble jump penalty, no delay slot.
            w_pc_nxt    = w_jump_target;
            w_instr_nxt = NOP;
            w_pcp4_nxt  = '0;
            w_valid_nxt = 1'b0;
        end else begin
            w_pc_nxt    = w_pc_plus4;
            w_instr_nxt = bus.InstrF;
            w_pcp4_nxt  = w_pc_plus4;
            w_valid_nxt = 1'b1;
            w_count_nxt = r_count + 32'd1;
        end
    end

    // PC and IF/ID registers; reset discards everything mid-stream too.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP;
            r_pcp4  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pcp4  <= w_pcp4_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign bus.PCF        = r_pc;
    assign bus.InstrD     = r_instr;
    assign bus.PCp4D      = r_pcp4;
    assign bus.ValidD     = r_valid;
    assign bus.FetchCount = r_count;
    assign bus.JumpD      = w_jump;
    // Decode fields are zero-latency slices of the IF/ID word.
    assign bus.OpD        = r_instr[31:26];
    assign bus.RsD        = r_instr[25:21];
    assign bus.RtD        = r_instr[20:16];
    assign bus.RdD        = r_instr[15:11];
    assign bus.ShamtD     = r_instr[10:6];
    assign bus.FunctD     = r_instr[5:0];
    assign bus.ImmD       = r_instr[HWL-1:0];
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized hazards/branches,
// every cycle compared against a cycle-level reference model of the stage.
module tb_fetch_stage;
    logic clk;
    logic rst;

    fetch_stage_if #(.WL(32), .HWL(16)) bus ();

    fetch_stage #(
        .WL(32), .HWL(16), .RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // IMEM: 512 words, aliased on address bits [10:2].
    logic [31:0] mem [0:511];
    assign bus.InstrF = mem[bus.PCF[10:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what the stage should be holding after each edge.
    logic [31:0] m_pc, m_ins, m_p4, m_cnt;
    logic        m_vld, m_boot;

    function automatic logic is_jump(input logic v, input logic [31:0] w);
        return v && (w[31:26] == 6'h02 || w[31:26] == 6'h03);
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_vld = 1'b0;
            m_cnt = 32'h0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (bus.BranchTaken) begin
            m_pc = bus.BranchTarget; m_ins = 32'h0; m_vld = 1'b0;
        end else if (bus.Stall) begin
            // nothing moves
        end else if (is_jump(m_vld, m_ins)) begin
            m_pc = {m_p4[31:28], m_ins[25:0], 2'b00};
            m_ins = 32'h0; m_vld = 1'b0;
        end else begin
            m_ins = mem[m_pc[10:2]];
            m_pc  = m_pc + 32'd4;
            m_p4  = m_pc;
            m_vld = 1'b1;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("PCF",        bus.PCF,                 m_pc);
        chk("ValidD",     32'(bus.ValidD),         32'(m_vld));
        chk("InstrD",     bus.InstrD,              m_ins);
        chk("FetchCount", bus.FetchCount,          m_cnt);
        chk("JumpD",      32'(bus.JumpD),          32'(is_jump(m_vld, m_ins)));
        chk("OpD",        32'(bus.OpD),            32'(m_ins >> 26));
        chk("RsD",        32'(bus.RsD),            (m_ins >> 21) & 32'h1F);
        chk("RtD",        32'(bus.RtD),            (m_ins >> 16) & 32'h1F);
        chk("RdD",        32'(bus.RdD),            (m_ins >> 11) & 32'h1F);
        chk("ShamtD",     32'(bus.ShamtD),         (m_ins >> 6) & 32'h1F);
        chk("FunctD",     32'(bus.FunctD),         m_ins & 32'h3F);
        chk("ImmD",       32'(bus.ImmD),           m_ins & 32'hFFFF);
        if (m_vld) chk("PCp4D", bus.PCp4D, m_p4);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [6];
        ops = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h23, 6'h2B};
        return {ops[$urandom_range(5)], 26'($urandom)};
    endfunction

    initial begin
        rst = 1'b1;
        bus.Stall = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.BranchTarget = 32'h0;
        for (int i = 0; i < 512; i++) mem[i] = {6'h00, 26'($urandom)};
        m_pc = 0; m_ins = 0; m_p4 = 0; m_vld = 0; m_cnt = 0; m_boot = 1;

        // T1: reset, then straight-line ALU ops
        step();
        chk("reset_PCF", bus.PCF, 32'h0);
        chk("reset_ValidD", 32'(bus.ValidD), 32'h0);
        chk("reset_Count", bus.FetchCount, 32'h0);
        rst = 1'b0;
        step();                                   // BOOT -> RUN, PC held
        chk("T1_boot_PCF", bus.PCF, 32'h0);
        step();                                   // first capture
        chk("T1_first_InstrD", bus.InstrD, mem[0]);
        chk("T1_first_PCp4D", bus.PCp4D, 32'h4);
        step();                                   // PCF = 8

        // T2: three stall cycles at PCF=8
        bus.Stall = 1'b1;
        repeat (3) step();
        chk("T2_hold_PCF", bus.PCF, 32'h8);
        bus.Stall = 1'b0;
        repeat (8) step();

        // T3: J to 0x100 sitting at PC=4
        mem[1] = {6'h02, 26'h40};
        do_reset();
        repeat (3) step();                        // InstrD = J
        chk("T3_JumpD", 32'(bus.JumpD), 32'h1);
        step();
        chk("T3_jump_PCF", bus.PCF, 32'h100);
        chk("T3_bubble", 32'(bus.ValidD), 32'h0);
        step();
        chk("T3_target_InstrD", bus.InstrD, mem[64]);
        chk("T3_target_PCp4D", bus.PCp4D, 32'h104);

        // T4: branch beats stall; branch beats a pending jump
        do_reset();
        repeat (2) step();
        bus.Stall = 1'b1; bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h200;
        step();
        chk("T4_br_stall_PCF", bus.PCF, 32'h200);
        bus.Stall = 1'b0; bus.BranchTaken = 1'b0;
        repeat (2) step();
        do_reset();
        repeat (3) step();                        // J valid in ID
        bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h300;
        step();
        chk("T4_br_vs_jump_PCF", bus.PCF, 32'h300);
        bus.BranchTaken = 1'b0;
        repeat (2) step();

        // T5: PC wrap, misaligned target, mid-stream reset
        mem[511] = {6'h00, 26'h123_4567};
        bus.BranchTaken = 1'b1; bus.BranchTarget = 32'hFFFF_FFFC;
        step();
        bus.BranchTaken = 1'b0;
        step();
        chk("T5_wrap_PCF", bus.PCF, 32'h0);
        chk("T5_wrap_PCp4D", bus.PCp4D, 32'h0);
        bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h0000_0012;
        step();
        bus.BranchTaken = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("T5_rst_PCF", bus.PCF, 32'h0);
        chk("T5_rst_Count", bus.FetchCount, 32'h0);
        rst = 1'b0;

        // Randomized mix of instructions, stalls, branches and resets
        for (int i = 0; i < 512; i++) mem[i] = rand_instr();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(49) == 0);
            bus.Stall = ($urandom_range(3) == 0);
            bus.BranchTaken = ($urandom_range(9) == 0);
            bus.BranchTarget = ($urandom_range(7) == 0) ? $urandom
                                                        : ($urandom & 32'h0000_07FC);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
